hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard and forwarding controller for the in-order integer pipeline.
//  Holds the destination tags of every in-flight instruction between decode and
//  register-file writeback, and drives one forwarding select per register read port.
//  Raises a load-use stall when a needed result is not yet available and honours
//  branch flushes. Sits beside the decoder; replaces the single-stage RA/RB-vs-last-RD compare.
// PARAMETERS
//  REG_ADDRESS_LENGTH  5  register address width
//  NUM_STAGES          3  tracked stages after decode, 1..NUM_STAGES; NUM_STAGES = RF-write stage
//  NUM_READ_PORTS      2  decode-stage register read ports
//  LOAD_READY_STAGE    2  first stage index at which load data is forwardable (1..NUM_STAGES)
//  SEL_W     $clog2(NUM_STAGES+1)  derived, not overridable
// PORTS
//  clk           in   1                          clock, rising edge
//  rst           in   1                          synchronous reset, active-high
//  issue_valid   in   1                          decode stage holds a valid instruction
//  issue_we      in   1                          decoded instruction writes a register
//  issue_load    in   1                          decoded instruction is a load
//  issue_rd      in   REG_ADDRESS_LENGTH         destination register
//  src_addr      in   NUM_READ_PORTS*REG_ADDRESS_LENGTH  source addresses, port p at [p*RAL +: RAL]
//  src_used      in   NUM_READ_PORTS             port p actually reads its source
//  flush         in   1                          branch taken: kill the decode-stage instruction
//  stall         out  1                          hold PC and IF/ID; bubble into stage 1
//  issue_accept  out  1                          decode instruction enters stage 1 this cycle
//  fwd_sel       out  NUM_READ_PORTS*SEL_W       0 = RF data, k = result of stage k
//  wb_valid      out  1                          stage NUM_STAGES holds a writing instruction
//  wb_rd         out  REG_ADDRESS_LENGTH         its destination
//  stall_count   out  16                         saturating count of stall cycles
// BEHAVIOUR
//  - Per stage k: registered {valid, we, load, rd}. All clear on rst; stall_count = 0.
//    Outputs during/after rst: stall=0, issue_accept=0, fwd_sel=0, wb_valid=0, wb_rd=0.
//  - Every cycle, stage k+1 <= stage k. Stage 1 <= decode tag if issue_accept, else a bubble.
//    The shift never holds; only decode/IF stall.
//  - Match: stage k valid & we & rd == src_addr[p] & src_used[p].
//    fwd_sel[p] is the smallest matching k (youngest wins), else 0.
//    Combinational from the current stage contents and src_addr, same cycle as decode.
//  - Stage NUM_STAGES writes the RF at this clock edge, so the RF read still returns old data.
//    A match there must forward (sel = NUM_STAGES).
//  - stall = issue_valid & ~flush & (some port's winning stage k has load=1 and k < LOAD_READY_STAGE).
//    The stall repeats each cycle until the load reaches LOAD_READY_STAGE.
//  - issue_accept = issue_valid & ~flush & ~stall.
//  - flush and stall in the same cycle: flush wins. stall=0, nothing issued, bubble into stage 1.
//    In-flight stages are not flushed; branches resolve in decode.
//  - issue_we=0: the tag enters with we=0 and never matches.
//  - stall_count increments on every stall cycle and saturates at 16'hFFFF.
//  - rst mid-stall: all tags cleared next cycle, stall drops immediately after the reset edge.
// CONFIGURATION
//  - HFU_R0_ZERO_EN defined: register 0 is hardwired zero. Address 0 never matches,
//    never forwards, never stalls. Tags with rd=0 enter with we forced to 0.
//  - Not defined: register 0 is an ordinary register.
// STRUCTURE
//  - Package hazard_pkg: SEL_W computation function; FWD_SEL_RF = 0 constant;
//    stage-tag struct {valid, we, load, rd}.
//  - One sub-module, fwd_match: one read port's priority compare across all stages.
//    Outputs that port's sel and its needs_stall flag. Instantiated NUM_READ_PORTS times.
// TESTING
//  - Back-to-back ALU ops: r3 <- r1+r2, next reads r3 on port 0.
//    -> fwd_sel[0]=1, stall=0. One cycle later with no rewrite -> sel=2.
//  - Load r4 then immediate use of r4 (LOAD_READY_STAGE=2).
//    -> stall=1 for exactly 1 cycle, then sel=2, issue_accept=1, stall_count=1.
//  - r5 written by stages 1 and 3, decode reads r5.
//    -> sel=1 (youngest). Read matching only stage 3 -> sel=3, not 0.
//  - flush=1 together with a load-use condition.
//    -> stall=0, issue_accept=0; stage 1 bubble next cycle; wb_valid low 3 cycles later.
//  - rst asserted while a stall is active.
//    -> next cycle all outputs 0 and stall_count=0. Stall 70000 cycles -> stall_count holds 16'hFFFF.
//  - HFU_R0_ZERO_EN: write r0 then read r0 -> sel=0, no stall. Without the macro -> sel=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard / forwarding controller.
//   FWD_SEL_RF  : forwarding select value meaning "use register-file data"
//   TAG_RD_W    : storage width of the rd field in a stage tag. The top zero-extends
//                 its register address into this field, so REG_ADDRESS_LENGTH must
//                 not exceed it.
//   stage_tag_t : per-stage record {valid, we, load, rd}
//   sel_width() : width of one forwarding select for a given stage count
package hazard_pkg;

    localparam int FWD_SEL_RF = 0;
    localparam int TAG_RD_W   = 8;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic                load;
        logic [TAG_RD_W-1:0] rd;
    } stage_tag_t;

    function automatic int sel_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority compare of one register read port against every tracked stage.
// Build option: HFU_R0_ZERO_EN (register 0 is hardwired zero and never matches).
// Ports:
//   tags        in  stage tags, index 1 = youngest, NUM_STAGES = RF-write stage
//   src         in  source register address of this port
//   used        in  port actually reads its source
//   sel         out smallest matching stage index, or FWD_SEL_RF when none matches
//   needs_stall out winning stage holds a load whose data is not yet forwardable
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int NUM_STAGES         = 3,
    parameter int LOAD_READY_STAGE   = 2,
    parameter int SEL_W              = 2
) (
    input  stage_tag_t [NUM_STAGES:1]       tags,
    input  logic [REG_ADDRESS_LENGTH-1:0]   src,
    input  logic                            used,
    output logic [SEL_W-1:0]                sel,
    output logic                            needs_stall
);

    logic src_live;
    logic found;

`ifdef HFU_R0_ZERO_EN
    assign src_live = used & (src != '0);
`else
    assign src_live = used;
`endif

    // Walk from the youngest stage outward; the first hit carries the newest value.
    always_comb begin
        sel         = SEL_W'(FWD_SEL_RF);
        needs_stall = 1'b0;
        found       = 1'b0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            if (!found && src_live && tags[k].valid && tags[k].we &&
                (tags[k].rd == TAG_RD_W'(src))) begin
                found       = 1'b1;
                sel         = SEL_W'(k);
                needs_stall = tags[k].load && (k < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the in-order integer pipeline.
// Tracks destination tags of in-flight instructions from decode to RF writeback,
// produces one forwarding select per read port, raises load-use stalls and
// honours branch flushes of the decode-stage instruction.
// Build option: HFU_R0_ZERO_EN (register 0 hardwired zero).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   issue_valid/we/load  decode-stage instruction attributes
//   issue_rd             its destination register
//   src_addr, src_used   per-port source addresses (port p at [p*RAL +: RAL]) and use flags
//   flush                kill the decode-stage instruction
//   stall                hold PC and IF/ID, bubble into stage 1
//   issue_accept         decode instruction enters stage 1 this cycle
//   fwd_sel              per-port select, 0 = RF, k = stage k result
//   wb_valid, wb_rd      RF-write stage holds a writing instruction, and its rd
//   stall_count          saturating count of stall cycles
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter  int REG_ADDRESS_LENGTH = 5,
    parameter  int NUM_STAGES         = 3,
    parameter  int NUM_READ_PORTS     = 2,
    parameter  int LOAD_READY_STAGE   = 2,
    localparam int SEL_W              = sel_width(NUM_STAGES)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         issue_valid,
    input  logic                                         issue_we,
    input  logic                                         issue_load,
    input  logic [REG_ADDRESS_LENGTH-1:0]                issue_rd,
    input  logic [NUM_READ_PORTS*REG_ADDRESS_LENGTH-1:0] src_addr,
    input  logic [NUM_READ_PORTS-1:0]                    src_used,
    input  logic                                         flush,
    output logic                                         stall,
    output logic                                         issue_accept,
    output logic [NUM_READ_PORTS*SEL_W-1:0]              fwd_sel,
    output logic                                         wb_valid,
    output logic [REG_ADDRESS_LENGTH-1:0]                wb_rd,
    output logic [15:0]                                  stall_count
);

    stage_tag_t [NUM_STAGES:1]       stage_q;
    stage_tag_t [NUM_STAGES:1]       stage_d;
    logic [15:0]                     stall_count_q;
    logic [15:0]                     stall_count_d;

    logic [NUM_READ_PORTS*SEL_W-1:0] sel_raw;
    logic [NUM_READ_PORTS-1:0]       port_stall;
    logic                            load_hazard;
    logic                            issue_we_eff;

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        fwd_match #(
            .REG_ADDRESS_LENGTH (REG_ADDRESS_LENGTH),
            .NUM_STAGES         (NUM_STAGES),
            .LOAD_READY_STAGE   (LOAD_READY_STAGE),
            .SEL_W              (SEL_W)
        ) u_match (
            .tags        (stage_q),
            .src         (src_addr[p*REG_ADDRESS_LENGTH +: REG_ADDRESS_LENGTH]),
            .used        (src_used[p]),
            .sel         (sel_raw[p*SEL_W +: SEL_W]),
            .needs_stall (port_stall[p])
        );
    end

`ifdef HFU_R0_ZERO_EN
    assign issue_we_eff = issue_we & (issue_rd != '0);
`else
    assign issue_we_eff = issue_we;
`endif

    assign load_hazard = |port_stall;

    // Outputs are gated with rst so they read zero while reset is held, even
    // before the first reset edge has cleared the stage tags. Flush wins over stall.
    assign stall        = ~rst & issue_valid & ~flush & load_hazard;
    assign issue_accept = ~rst & issue_valid & ~flush & ~load_hazard;
    assign fwd_sel      = rst ? '0 : sel_raw;
    assign wb_valid     = ~rst & stage_q[NUM_STAGES].valid & stage_q[NUM_STAGES].we;
    assign wb_rd        = wb_valid ? stage_q[NUM_STAGES].rd[REG_ADDRESS_LENGTH-1:0] : '0;
    assign stall_count  = stall_count_q;

    // The stage shift never holds; a stalled or flushed decode just inserts a bubble.
    always_comb begin
        stage_d = '0;
        if (issue_accept) begin
            stage_d[1].valid = 1'b1;
            stage_d[1].we    = issue_we_eff;
            stage_d[1].load  = issue_load;
            stage_d[1].rd    = TAG_RD_W'(issue_rd);
        end
        for (int k = 2; k <= NUM_STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q       <= '0;
            stall_count_q <= '0;
        end else begin
            stage_q       <= stage_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_we, issue_load, flush;
    logic [4:0]  issue_rd;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic        stall, issue_accept, wb_valid;
    logic [3:0]  fwd_sel;
    logic [4:0]  wb_rd;
    logic [15:0] stall_count;

    // Deep-pipeline instance used only for the saturation scenario.
    logic        s_valid, s_we, s_load, s_flush;
    logic [4:0]  s_rd;
    logic [9:0]  s_src;
    logic [1:0]  s_used;
    logic        s_stall, s_accept, s_wb_valid;
    logic [9:0]  s_fwd_sel;
    logic [4:0]  s_wb_rd;
    logic [15:0] s_stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_load(issue_load), .issue_rd(issue_rd), .src_addr(src_addr),
        .src_used(src_used), .flush(flush), .stall(stall), .issue_accept(issue_accept),
        .fwd_sel(fwd_sel), .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_count(stall_count)
    );

    hazard_fwd_unit #(.NUM_STAGES(16), .LOAD_READY_STAGE(16)) sat_dut (
        .clk(clk), .rst(rst), .issue_valid(s_valid), .issue_we(s_we),
        .issue_load(s_load), .issue_rd(s_rd), .src_addr(s_src),
        .src_used(s_used), .flush(s_flush), .stall(s_stall), .issue_accept(s_accept),
        .fwd_sel(s_fwd_sel), .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .stall_count(s_stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                          input logic [4:0] s0, input logic u0, input logic [4:0] s1,
                          input logic u1, input logic fl);
        issue_valid = v;  issue_we = we;  issue_load = ld;  issue_rd = rd;
        src_addr = {s1, s0};  src_used = {u1, u0};  flush = fl;
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 1, 1, 5'd4, 5'd4, 1, 5'd4, 1, 0);
        tick();
        tick();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall); end
        n_checks++; if (issue_accept !== 1'b0) begin n_fail++; $display("FAIL rst_accept got %b want 0", issue_accept); end
        n_checks++; if (fwd_sel !== 4'd0) begin n_fail++; $display("FAIL rst_fwd_sel got %h want 0", fwd_sel); end
        n_checks++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL rst_wb got %b/%0d want 0/0", wb_valid, wb_rd); end
        n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", stall_count); end
        n_checks++; if (s_stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_sat_count got %0d want 0", s_stall_count); end
        idle(1);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_back_to_back();
        set_in(1, 1, 0, 5'd3, 5'd1, 1, 5'd2, 1, 0);
        n_checks++; if (fwd_sel !== 4'h0 || issue_accept !== 1'b1) begin n_fail++; $display("FAIL b2b_first got sel=%h acc=%b want 0/1", fwd_sel, issue_accept); end
        tick();
        set_in(1, 1, 0, 5'd6, 5'd3, 1, 5'd0, 0, 0);
        n_checks++; if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_sel1 got sel=%0d stall=%b want 1/0", fwd_sel[1:0], stall); end
        tick();
        set_in(1, 1, 0, 5'd7, 5'd3, 1, 5'd6, 1, 0);
        n_checks++; if (fwd_sel !== {2'd1, 2'd2}) begin n_fail++; $display("FAIL b2b_sel2 got %h want %h", fwd_sel, {2'd1, 2'd2}); end
        tick();
        set_in(0, 0, 0, 5'd0, 5'd3, 1, 5'd7, 1, 0);
        n_checks++; if (fwd_sel !== {2'd1, 2'd3}) begin n_fail++; $display("FAIL b2b_sel3 got %h want %h", fwd_sel, {2'd1, 2'd3}); end
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3) begin n_fail++; $display("FAIL b2b_wb got %b/%0d want 1/3", wb_valid, wb_rd); end
        n_checks++; if (issue_accept !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got acc=%b stall=%b want 0/0", issue_accept, stall); end
        tick();
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd6) begin n_fail++; $display("FAIL b2b_wb2 got %b/%0d want 1/6", wb_valid, wb_rd); end
        idle(4);
    endtask

    task automatic test_load_use();
        set_in(1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0);
        tick();
        set_in(1, 1, 0, 5'd8, 5'd4, 1, 5'd0, 0, 0);
        n_checks++; if (stall !== 1'b1 || issue_accept !== 1'b0) begin n_fail++; $display("FAIL lu_stall got stall=%b acc=%b want 1/0", stall, issue_accept); end
        tick();
        exp_cnt++;
        n_checks++; if (stall !== 1'b0 || issue_accept !== 1'b1) begin n_fail++; $display("FAIL lu_release got stall=%b acc=%b want 0/1", stall, issue_accept); end
        n_checks++; if (fwd_sel[1:0] !== 2'd2) begin n_fail++; $display("FAIL lu_sel got %0d want 2", fwd_sel[1:0]); end
        n_checks++; if (stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL lu_count got %0d want %0d", stall_count, exp_cnt); end
        tick();
        idle(1);
        n_checks++; if (stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL lu_count_hold got %0d want %0d", stall_count, exp_cnt); end
        idle(4);
    endtask

    task automatic test_youngest();
        set_in(1, 1, 0, 5'd5, 5'd0, 0, 5'd0, 0, 0);
        tick();
        set_in(1, 1, 0, 5'd9, 5'd0, 0, 5'd0, 0, 0);
        tick();
        set_in(1, 1, 0, 5'd5, 5'd0, 0, 5'd0, 0, 0);
        tick();
        set_in(0, 0, 0, 5'd0, 5'd5, 1, 5'd9, 1, 0);
        n_checks++; if (fwd_sel !== {2'd2, 2'd1}) begin n_fail++; $display("FAIL young_sel got %h want %h", fwd_sel, {2'd2, 2'd1}); end
        set_in(0, 0, 0, 5'd0, 5'd5, 0, 5'd9, 0, 0);
        n_checks++; if (fwd_sel !== 4'h0) begin n_fail++; $display("FAIL young_unused got %h want 0", fwd_sel); end
        tick();
        set_in(0, 0, 0, 5'd0, 5'd9, 1, 5'd5, 1, 0);
        n_checks++; if (fwd_sel !== {2'd2, 2'd3}) begin n_fail++; $display("FAIL young_stage3 got %h want %h", fwd_sel, {2'd2, 2'd3}); end
        idle(4);
    endtask

    task automatic test_flush();
        set_in(1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0);
        tick();
        set_in(1, 1, 0, 5'd10, 5'd4, 1, 5'd0, 0, 1);
        n_checks++; if (stall !== 1'b0 || issue_accept !== 1'b0) begin n_fail++; $display("FAIL fl_out got stall=%b acc=%b want 0/0", stall, issue_accept); end
        tick();
        set_in(0, 0, 0, 5'd0, 5'd4, 1, 5'd10, 1, 0);
        n_checks++; if (fwd_sel !== {2'd0, 2'd2}) begin n_fail++; $display("FAIL fl_bubble got %h want %h", fwd_sel, {2'd0, 2'd2}); end
        n_checks++; if (stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL fl_count got %0d want %0d", stall_count, exp_cnt); end
        tick();
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4) begin n_fail++; $display("FAIL fl_wb_load got %b/%0d want 1/4", wb_valid, wb_rd); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_wb_bubble got %b want 0", wb_valid); end
        idle(4);
    endtask

    task automatic test_we0();
        set_in(1, 0, 0, 5'd11, 5'd0, 0, 5'd0, 0, 0);
        n_checks++; if (issue_accept !== 1'b1) begin n_fail++; $display("FAIL we0_accept got %b want 1", issue_accept); end
        tick();
        set_in(0, 0, 0, 5'd0, 5'd11, 1, 5'd11, 1, 0);
        n_checks++; if (fwd_sel !== 4'h0) begin n_fail++; $display("FAIL we0_sel got %h want 0", fwd_sel); end
        idle(4);
    endtask

    task automatic test_r0();
        logic [1:0] exp_sel;
        logic       exp_stall;
`ifdef HFU_R0_ZERO_EN
        exp_sel = 2'd0;  exp_stall = 1'b0;
`else
        exp_sel = 2'd1;  exp_stall = 1'b1;
`endif
        set_in(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        tick();
        set_in(0, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0);
        n_checks++; if (fwd_sel[1:0] !== exp_sel) begin n_fail++; $display("FAIL r0_sel got %0d want %0d", fwd_sel[1:0], exp_sel); end
        idle(4);
        set_in(1, 1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        tick();
        set_in(1, 1, 0, 5'd12, 5'd0, 1, 5'd0, 0, 0);
        n_checks++; if (stall !== exp_stall) begin n_fail++; $display("FAIL r0_stall got %b want %b", stall, exp_stall); end
        tick();
        if (exp_stall) exp_cnt++;
        idle(4);
        n_checks++; if (stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL r0_count got %0d want %0d", stall_count, exp_cnt); end
    endtask

    task automatic test_rst_mid_stall();
        set_in(1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0);
        tick();
        set_in(1, 1, 0, 5'd8, 5'd4, 1, 5'd0, 0, 0);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rm_pre got %b want 1", stall); end
        rst = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0 || issue_accept !== 1'b0) begin n_fail++; $display("FAIL rm_during got stall=%b acc=%b want 0/0", stall, issue_accept); end
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        n_checks++; if (stall !== 1'b0 || issue_accept !== 1'b1) begin n_fail++; $display("FAIL rm_after got stall=%b acc=%b want 0/1", stall, issue_accept); end
        n_checks++; if (fwd_sel !== 4'h0 || wb_valid !== 1'b0 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL rm_outs got sel=%h wb=%b/%0d want 0/0/0", fwd_sel, wb_valid, wb_rd); end
        n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rm_count got %0d want 0", stall_count); end
        idle(4);
    endtask

    // A self-dependent load keeps the deep instance stalled 15 of every 16 cycles.
    task automatic test_saturation();
        s_valid = 1'b1;  s_we = 1'b1;  s_load = 1'b1;  s_rd = 5'd4;
        s_src = {5'd0, 5'd4};  s_used = 2'b01;  s_flush = 1'b0;
        #1;
        for (int i = 0; i < 1600; i++) tick();
        n_checks++; if (s_stall_count !== 16'd1500) begin n_fail++; $display("FAIL sat_partial got %0d want 1500", s_stall_count); end
        for (int i = 0; i < 68400; i++) tick();
        n_checks++; if (s_stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", s_stall_count); end
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;  s_we = 1'b0;  s_load = 1'b0;  s_rd = '0;
        s_src = '0;  s_used = '0;  s_flush = 1'b0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_youngest();
        test_flush();
        test_we0();
        test_r0();
        test_rst_mid_stall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
